// File: rtl/simd_exec_sequencer_if.sv
// Bus bundle between the SIMD execution sequencer, its BRAMs, the fetch unit and the control block.
// The master modport is the sequencer side; slave is the memory/control environment side.
interface simd_exec_sequencer_if #(
    parameter int BRAM_DEPTH       = 10,
    parameter int INSTR_BRAM_DEPTH = 11
);
    logic                        VALID_FU2PE;
    logic [INSTR_BRAM_DEPTH-1:0] instr_rd_addr;
    logic                        instr_rd_en;
    logic [31:0]                 instr_dout;
    logic [BRAM_DEPTH-1:0]       mat_a_rd_addr;
    logic [BRAM_DEPTH-1:0]       mat_b_rd_addr;
    logic                        mat_a_rd_en;
    logic                        mat_b_rd_en;
    logic [31:0]                 mat_a_dout;
    logic [31:0]                 mat_b_dout;
    logic [BRAM_DEPTH-1:0]       res_addr;
    logic [31:0]                 res_din;
    logic                        res_we;
    logic                        busy;
    logic                        done;
    logic                        err;

    modport master (
        input  VALID_FU2PE, instr_dout, mat_a_dout, mat_b_dout,
        output instr_rd_addr, instr_rd_en, mat_a_rd_addr, mat_b_rd_addr,
        output mat_a_rd_en, mat_b_rd_en, res_addr, res_din, res_we, busy, done, err
    );

    modport slave (
        output VALID_FU2PE, instr_dout, mat_a_dout, mat_b_dout,
        input  instr_rd_addr, instr_rd_en, mat_a_rd_addr, mat_b_rd_addr,
        input  mat_a_rd_en, mat_b_rd_en, res_addr, res_din, res_we, busy, done, err
    );
endinterface

// File: rtl/simd_exec_sequencer.sv
// Instruction-driven 4-lane 8-bit SIMD sequencer: fetch/decode from instruction BRAM,
// stream operands from two BRAMs, write lane results two cycles after each read issue.
module simd_exec_sequencer #(
    parameter int BRAM_DEPTH       = 10,
    parameter int INSTR_BRAM_DEPTH = 11
) (
    input logic                   ACLK,
    input logic                   ARESET,
    simd_exec_sequencer_if.master bus
);
    localparam int DATA_W = 32;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_MAX  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_DRAIN, S_DONE} state_t;

    state_t                      r_state, w_next;
    logic [INSTR_BRAM_DEPTH-1:0] r_pc;
    logic [3:0]                  r_op;
    logic [9:0]                  r_len, r_idx;
    logic [BRAM_DEPTH-1:0]       r_base;
    logic                        r_drain, r_last, r_err;
    logic                        r_vld_p1, r_vld_p2;
    logic [BRAM_DEPTH-1:0]       r_addr_p1, r_addr_p2;
    logic [DATA_W-1:0]           r_data_p2;

    logic [3:0]                  w_dec_op;
    logic [9:0]                  w_dec_len;
    logic                        w_dec_legal, w_dec_skip, w_pc_end;
    logic                        w_instr_en, w_exec, w_rd_en;
    logic [BRAM_DEPTH-1:0]       w_rd_addr;
    logic                        w_unused_bits;

    function automatic logic [DATA_W-1:0] simd_alu(input logic [3:0] op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] res;
        logic [7:0]        x, y, lane;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            x = a[8*k +: 8];
            y = b[8*k +: 8];
            case (op)
                OP_ADD:  lane = x + y;
                OP_SUB:  lane = x - y;
                OP_MUL:  lane = x * y;
                OP_MAX:  lane = (x > y) ? x : y;
                default: lane = 8'h00;
            endcase
            res[8*k +: 8] = lane;
        end
        return res;
    endfunction

    assign w_dec_op      = bus.instr_dout[31:28];
    assign w_dec_len     = bus.instr_dout[25:16];
    assign w_dec_legal   = (w_dec_op <= OP_MAX) || (w_dec_op == OP_HALT);
    assign w_dec_skip    = (w_dec_op == OP_NOP) || (w_dec_len == 10'd0) || !w_dec_legal;
    assign w_pc_end      = (r_pc == {INSTR_BRAM_DEPTH{1'b1}});
    assign w_unused_bits = ^{bus.instr_dout[27:26], bus.instr_dout[15:10]};
    assign w_rd_addr     = r_base + BRAM_DEPTH'(r_idx);
    assign w_rd_en       = w_exec && !ARESET;

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_instr_en = 1'b0;
        w_exec     = 1'b0;
        case (r_state)
            S_IDLE:   if (bus.VALID_FU2PE) w_next = S_FETCH;
            S_FETCH: begin
                w_instr_en = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                if (w_dec_op == OP_HALT) w_next = S_DONE;
                else if (w_dec_skip)     w_next = w_pc_end ? S_DONE : S_FETCH;
                else                     w_next = S_EXEC;
            end
            S_EXEC: begin
                w_exec = 1'b1;
                if (r_idx == r_len - 10'd1) w_next = S_DRAIN;
            end
            S_DRAIN:  if (r_drain) w_next = r_last ? S_DONE : S_FETCH;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Control state: program counter, element index, drain counter, error flag, valid pipe
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_pc     <= '0;
            r_idx    <= '0;
            r_drain  <= 1'b0;
            r_last   <= 1'b0;
            r_err    <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p1 <= w_exec;
            r_vld_p2 <= r_vld_p1;
            case (r_state)
                S_IDLE: if (bus.VALID_FU2PE) begin
                    r_pc  <= '0;
                    r_err <= 1'b0;
                end
                S_DECODE: begin
                    r_pc    <= r_pc + 1'b1;
                    r_idx   <= '0;
                    r_drain <= 1'b0;
                    r_last  <= w_pc_end;
                    if (!w_dec_legal) r_err <= 1'b1;
                end
                S_EXEC:  r_idx   <= r_idx + 10'd1;
                S_DRAIN: r_drain <= !r_drain;
                default: ;
            endcase
        end
    end

    // p0: read issue; p1: operand data returns and is combined; p2: registered result
    always_ff @(posedge ACLK) begin
        if (r_state == S_DECODE) begin
            r_op   <= w_dec_op;
            r_len  <= w_dec_len;
            r_base <= BRAM_DEPTH'(bus.instr_dout[9:0]);
        end
        r_addr_p1 <= w_rd_addr;
        r_addr_p2 <= r_addr_p1;
        r_data_p2 <= simd_alu(r_op, bus.mat_a_dout, bus.mat_b_dout);
    end

    assign bus.instr_rd_en   = w_instr_en && !ARESET;
    assign bus.instr_rd_addr = w_instr_en ? r_pc : '0;
    assign bus.mat_a_rd_en   = w_rd_en;
    assign bus.mat_b_rd_en   = w_rd_en;
    assign bus.mat_a_rd_addr = w_rd_en ? w_rd_addr : '0;
    assign bus.mat_b_rd_addr = w_rd_en ? w_rd_addr : '0;
    assign bus.res_we        = r_vld_p2 && !ARESET;
    assign bus.res_addr      = r_vld_p2 ? r_addr_p2 : '0;
    assign bus.res_din       = r_vld_p2 ? r_data_p2 : '0;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = (r_state == S_DONE);
    assign bus.err           = r_err;
endmodule

// File: tb/tb_simd_exec_sequencer.sv
// Directed bench for simd_exec_sequencer: single-instruction lane vectors from a table,
// then hand-written programs for the multi-cycle corner cases.
module tb_simd_exec_sequencer;
    localparam int BD = 10;
    localparam int ID = 11;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    simd_exec_sequencer_if #(.BRAM_DEPTH(BD), .INSTR_BRAM_DEPTH(ID)) bus ();
    simd_exec_sequencer #(.BRAM_DEPTH(BD), .INSTR_BRAM_DEPTH(ID)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .bus(bus));

    logic [31:0] imem [0:2047];
    logic [31:0] amem [0:1023];
    logic [31:0] bmem [0:1023];
    logic [31:0] rmem [0:1023];
    int          rd_cyc [0:1023];
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic [9:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [9:0] len, input logic [9:0] base);
        return {op, 2'b00, len, 6'b000000, base};
    endfunction

    // Synchronous BRAM models with one cycle read latency
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (bus.instr_rd_en) bus.instr_dout <= imem[bus.instr_rd_addr];
        if (bus.mat_a_rd_en) bus.mat_a_dout <= amem[bus.mat_a_rd_addr];
        if (bus.mat_b_rd_en) bus.mat_b_dout <= bmem[bus.mat_b_rd_addr];
    end

    always @(negedge ACLK) begin
        if (bus.mat_a_rd_en) rd_cyc[bus.mat_a_rd_addr] = cyc;
        if (bus.res_we) begin
            rmem[bus.res_addr] = bus.res_din;
            wr_addr_q.push_back(bus.res_addr);
            wr_data_q.push_back(bus.res_din);
            wr_cnt++;
            chk("write latency", 32'(cyc - rd_cyc[bus.res_addr]), 32'd2);
        end
        if (bus.done) done_cnt++;
    end

    task automatic clear_prog();
        for (int i = 0; i < 2048; i++) imem[i] = 32'h0;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        @(posedge ACLK); #1 bus.VALID_FU2PE = 1'b1;
        @(posedge ACLK); #1 bus.VALID_FU2PE = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (n < 6000 && !got) begin
            @(negedge ACLK);
            if (bus.done) got = 1'b1;
            n++;
        end
        if (!got) chk({name, " done timeout"}, 32'd0, 32'd1);
        else begin
            @(negedge ACLK);
            chk({name, " busy/done after done"}, {30'd0, bus.busy, bus.done}, 32'd0);
        end
    endtask

    initial begin
        bus.VALID_FU2PE = 1'b0;
        bus.instr_dout  = '0;
        bus.mat_a_dout  = '0;
        bus.mat_b_dout  = '0;
        for (int i = 0; i < 1024; i++) begin
            amem[i] = '0; bmem[i] = '0; rmem[i] = '0; rd_cyc[i] = 0;
        end
        clear_prog();

        vecs[0] = '{"add carry lanes", 4'h1, 32'h01FF_7F80, 32'h0101_0180, 32'h0200_8000};
        vecs[1] = '{"mul low byte",    4'h3, 32'h1002_0304, 32'h1003_0202, 32'h0006_0608};
        vecs[2] = '{"sub borrow",      4'h2, 32'h1002_0304, 32'h1003_0202, 32'h00FF_0102};
        vecs[3] = '{"max unsigned",    4'h4, 32'h807F_00FF, 32'h7F80_01FE, 32'h8080_01FF};
        vecs[4] = '{"add no cross",    4'h1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FF00};
        vecs[5] = '{"mul wrap",        4'h3, 32'hFFFF_100F, 32'hFF02_1011, 32'h01FE_00FF};
        vecs[6] = '{"sub underflow",   4'h2, 32'h0000_0000, 32'h0101_0101, 32'hFFFF_FFFF};

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("reset ctrl", {25'd0, bus.instr_rd_en, bus.mat_a_rd_en, bus.mat_b_rd_en, bus.res_we,
                           bus.busy, bus.done, bus.err}, 32'd0);
        chk("reset addr", {1'b0, bus.instr_rd_addr, bus.mat_a_rd_addr, bus.res_addr}, 32'd0);
        chk("reset din", bus.res_din, 32'd0);
        @(posedge ACLK); #1 ARESET = 1'b0;

        for (int v = 0; v < 7; v++) begin
            logic [9:0] base;
            base = 10'(64 + v);
            clear_prog();
            imem[0] = mk(vecs[v].op, 10'd1, base);
            imem[1] = 32'hF000_0000;
            amem[base] = vecs[v].a;
            bmem[base] = vecs[v].b;
            rmem[base] = 32'hDEAD_BEEF;
            pulse_start();
            wait_done(vecs[v].name);
            chk({vecs[v].name, " result"}, rmem[base], vecs[v].exp);
            chk({vecs[v].name, " writes"}, wr_cnt, 32'd1);
            chk({vecs[v].name, " done pulses"}, done_cnt, 32'd1);
            chk({vecs[v].name, " err"}, {31'd0, bus.err}, 32'd0);
        end

        // ADD len 2 then HALT
        clear_prog();
        imem[0] = 32'h1002_0010;
        imem[1] = 32'hF000_0000;
        amem[16] = 32'h01FF_7F80; bmem[16] = 32'h0101_0180;
        amem[17] = 32'h0000_0010; bmem[17] = 32'h0000_0020;
        pulse_start();
        wait_done("add2");
        chk("add2 res16", rmem[16], 32'h0200_8000);
        chk("add2 res17", rmem[17], 32'h0000_0030);
        chk("add2 done pulses", done_cnt, 32'd1);

        // MUL then SUB on the same base
        clear_prog();
        imem[0] = mk(4'h3, 10'd1, 10'd32);
        imem[1] = mk(4'h2, 10'd1, 10'd32);
        imem[2] = 32'hF000_0000;
        amem[32] = 32'h1002_0304; bmem[32] = 32'h1003_0202;
        pulse_start();
        wait_done("mulsub");
        chk("mulsub writes", wr_cnt, 32'd2);
        if (wr_cnt == 2) begin
            chk("mulsub first", wr_data_q[0], 32'h0006_0608);
            chk("mulsub second", wr_data_q[1], 32'h00FF_0102);
        end
        chk("mulsub final", rmem[32], 32'h00FF_0102);

        // Address wrap across the top of the result space
        clear_prog();
        imem[0] = mk(4'h1, 10'd3, 10'h3FE);
        imem[1] = 32'hF000_0000;
        pulse_start();
        wait_done("wrap");
        chk("wrap writes", wr_cnt, 32'd3);
        if (wr_cnt == 3) begin
            chk("wrap addr0", {22'd0, wr_addr_q[0]}, 32'h3FE);
            chk("wrap addr1", {22'd0, wr_addr_q[1]}, 32'h3FF);
            chk("wrap addr2", {22'd0, wr_addr_q[2]}, 32'h000);
        end

        // Illegal opcode, then err clear on restart
        clear_prog();
        imem[0] = 32'h7000_0000;
        imem[1] = mk(4'h1, 10'd1, 10'd48);
        imem[2] = 32'hF000_0000;
        amem[48] = 32'h0102_0304; bmem[48] = 32'h1010_1010;
        rmem[48] = 32'h0;
        pulse_start();
        wait_done("illegal");
        chk("illegal err", {31'd0, bus.err}, 32'd1);
        chk("illegal add", rmem[48], 32'h1112_1314);
        chk("illegal done pulses", done_cnt, 32'd1);
        imem[0] = 32'h0000_0000;
        pulse_start();
        @(negedge ACLK);
        chk("err cleared on start", {31'd0, bus.err}, 32'd0);
        wait_done("restart");
        chk("restart err", {31'd0, bus.err}, 32'd0);

        // Start pulse during EXEC is ignored
        clear_prog();
        imem[0] = mk(4'h1, 10'd20, 10'd100);
        imem[1] = mk(4'h1, 10'd1, 10'd200);
        imem[2] = 32'hF000_0000;
        amem[200] = 32'h0000_0005; bmem[200] = 32'h0000_0007;
        pulse_start();
        repeat (5) @(posedge ACLK);
        #1 bus.VALID_FU2PE = 1'b1;
        @(posedge ACLK); #1 bus.VALID_FU2PE = 1'b0;
        wait_done("busy start");
        chk("busy start writes", wr_cnt, 32'd21);
        chk("busy start res200", rmem[200], 32'h0000_000C);
        chk("busy start done pulses", done_cnt, 32'd1);

        // Reset mid-EXEC, then restart from pc 0
        clear_prog();
        imem[0] = mk(4'h1, 10'd20, 10'd300);
        imem[1] = 32'hF000_0000;
        pulse_start();
        repeat (6) @(posedge ACLK);
        #1 ARESET = 1'b1;
        @(negedge ACLK);
        chk("reset cycle enables", {28'd0, bus.mat_a_rd_en, bus.mat_b_rd_en, bus.res_we, bus.instr_rd_en}, 32'd0);
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("post reset ctrl", {25'd0, bus.instr_rd_en, bus.mat_a_rd_en, bus.mat_b_rd_en, bus.res_we,
                                bus.busy, bus.done, bus.err}, 32'd0);
        begin
            int saved;
            saved = wr_cnt;
            repeat (10) @(negedge ACLK);
            chk("no writes after reset", wr_cnt, saved);
        end
        clear_prog();
        imem[0] = mk(4'h4, 10'd1, 10'd400);
        imem[1] = 32'hF000_0000;
        amem[400] = 32'h0A0B_F00D; bmem[400] = 32'hA00B_0FFF;
        pulse_start();
        wait_done("after reset");
        chk("after reset res", rmem[400], 32'hA00B_F0FF);
        chk("after reset writes", wr_cnt, 32'd1);

        // Implicit halt at the last instruction address
        clear_prog();
        imem[2047] = mk(4'h1, 10'd1, 10'd500);
        amem[500] = 32'h1111_1111; bmem[500] = 32'h2222_2222;
        pulse_start();
        wait_done("pc wrap");
        chk("pc wrap res", rmem[500], 32'h3333_3333);
        chk("pc wrap writes", wr_cnt, 32'd1);
        chk("pc wrap done pulses", done_cnt, 32'd1);
        chk("pc wrap err", {31'd0, bus.err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
